// File: rtl/i2s_capture_pkg.sv
// Shared audio constants: sample and stereo word widths, capture FSM encoding.
package i2s_capture_pkg;

    localparam int AUDIO_SAMPLE_W = 16;
    localparam int AUDIO_STEREO_W = 32;

    localparam logic [1:0] CAP_IDLE  = 2'd0;
    localparam logic [1:0] CAP_LEFT  = 2'd1;
    localparam logic [1:0] CAP_RIGHT = 2'd2;

endpackage

// File: rtl/i2s_capture_fifo.sv
// Generic first-word-fall-through synchronous FIFO with an extra pointer bit for full/empty.
module audio_sync_fifo
    import i2s_capture_pkg::*;
#(
    parameter int WIDTH = AUDIO_STEREO_W,
    parameter int DEPTH = 8
) (
    input  logic                     CLK,
    input  logic                     Reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q, rptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign level   = wptr_q - rptr_q;
    assign rdata   = empty ? '0 : mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else if (flush) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
            if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
        end
    end

    // NOTE: storage has no reset; empty gating on rdata keeps unwritten entries invisible.
    always_ff @(posedge CLK) begin
        if (do_push && !flush) mem_q[wptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/i2s_capture.sv
// I2S slave receiver: synchronises BCLK/WS/DATA into CLK, deserialises L/R slots, buffers stereo words.
module i2s_capture
    import i2s_capture_pkg::*;
#(
    parameter int SAMPLE_WIDTH = AUDIO_SAMPLE_W,
    parameter int FIFO_DEPTH   = 8,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                          CLK,
    input  logic                          Reset,
    input  logic                          Enable,
    input  logic                          I2S_CLK,
    input  logic                          I2S_WS,
    input  logic                          I2S_DATA,
    output logic [2*SAMPLE_WIDTH-1:0]     SampleData,
    output logic                          SampleValid,
    input  logic                          SampleReady,
    output logic [$clog2(FIFO_DEPTH):0]   FifoLevel,
    output logic                          Overflow,
    output logic                          FrameError,
    input  logic                          ClearFlags
);

    localparam int                CNT_W    = $clog2(SAMPLE_WIDTH) + 1;
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(SAMPLE_WIDTH - 1);
    localparam logic [CNT_W-1:0]  SLOT_LEN = CNT_W'(SAMPLE_WIDTH);

    logic [SYNC_STAGES-1:0]  bclk_sync_q, ws_sync_q, data_sync_q;
    logic                    bclk_q, bclk_rise, ws_s, data_s, ws_changed;
    logic                    ws_prev_q;
    logic [1:0]              state_q, state_d;
    logic [CNT_W-1:0]        bitcnt_q, bitcnt_d;
    logic [SAMPLE_WIDTH-1:0] sh_l_q, sh_l_d, sh_r_q, sh_r_d;
    logic                    push, frame_err_evt, ovf_evt;
    logic                    fifo_full, fifo_empty;
    logic                    overflow_q, frame_error_q;

    assign bclk_rise  = bclk_sync_q[SYNC_STAGES-1] && !bclk_q;
    assign ws_s       = ws_sync_q[SYNC_STAGES-1];
    assign data_s     = data_sync_q[SYNC_STAGES-1];
    assign ws_changed = ws_s ^ ws_prev_q;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            bclk_sync_q <= '0;
            ws_sync_q   <= '0;
            data_sync_q <= '0;
            bclk_q      <= 1'b0;
            ws_prev_q   <= 1'b0;
        end else begin
            bclk_sync_q <= {bclk_sync_q[SYNC_STAGES-2:0], I2S_CLK};
            ws_sync_q   <= {ws_sync_q[SYNC_STAGES-2:0], I2S_WS};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], I2S_DATA};
            bclk_q      <= bclk_sync_q[SYNC_STAGES-1];
            if (bclk_rise) ws_prev_q <= ws_s;
        end
    end

    // NOTE: every comb output gets a default first so no path leaves a latch behind.
    always_comb begin
        state_d       = state_q;
        bitcnt_d      = bitcnt_q;
        sh_l_d        = sh_l_q;
        sh_r_d        = sh_r_q;
        push          = 1'b0;
        frame_err_evt = 1'b0;
        if (!Enable) begin
            state_d  = CAP_IDLE;
            bitcnt_d = '0;
            sh_l_d   = '0;
            sh_r_d   = '0;
        end else if (bclk_rise) begin
            case (state_q)
                CAP_IDLE: begin
                    if (ws_prev_q && !ws_s) begin
                        state_d  = CAP_LEFT;
                        bitcnt_d = '0;
                    end
                end
                CAP_LEFT, CAP_RIGHT: begin
                    if (ws_changed && bitcnt_q < LAST_BIT) begin
                        frame_err_evt = 1'b1;
                        state_d       = CAP_IDLE;
                        bitcnt_d      = '0;
                        sh_l_d        = '0;
                        sh_r_d        = '0;
                    end else begin
                        // bitcnt saturates at SLOT_LEN; further bits in the slot are padding.
                        if (bitcnt_q < SLOT_LEN) begin
                            if (state_q == CAP_LEFT) sh_l_d = {sh_l_q[SAMPLE_WIDTH-2:0], data_s};
                            else                     sh_r_d = {sh_r_q[SAMPLE_WIDTH-2:0], data_s};
                            bitcnt_d = bitcnt_q + CNT_W'(1);
                            push     = (state_q == CAP_RIGHT) && (bitcnt_q == LAST_BIT);
                        end
                        if (ws_changed) begin
                            state_d  = (state_q == CAP_LEFT) ? CAP_RIGHT : CAP_LEFT;
                            bitcnt_d = '0;
                        end
                    end
                end
                default: state_d = CAP_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q  <= CAP_IDLE;
            bitcnt_q <= '0;
            sh_l_q   <= '0;
            sh_r_q   <= '0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            sh_l_q   <= sh_l_d;
            sh_r_q   <= sh_r_d;
        end
    end

    // A full FIFO with no pop this cycle drops the frame.
    assign ovf_evt = push && fifo_full && !SampleReady;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            overflow_q    <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            overflow_q    <= ovf_evt       || (overflow_q    && !ClearFlags);
            frame_error_q <= frame_err_evt || (frame_error_q && !ClearFlags);
        end
    end

    audio_sync_fifo #(
        .WIDTH (2*SAMPLE_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .Reset (Reset),
        .flush (!Enable),
        .push  (push),
        .pop   (SampleReady),
        .wdata ({sh_l_q, sh_r_q[SAMPLE_WIDTH-2:0], data_s}),
        .rdata (SampleData),
        .level (FifoLevel),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign SampleValid = !fifo_empty;
    assign Overflow    = overflow_q;
    assign FrameError  = frame_error_q;

endmodule

// File: tb/tb_i2s_capture.sv
// Directed/random bench for i2s_capture: acts as the I2S codec and checks against a frame-level queue model.
module tb_i2s_capture;

    localparam int SW    = 16;
    localparam int DEPTH = 8;
    localparam int SYNC  = 2;

    logic        CLK = 1'b0;
    logic        Reset, Enable, I2S_CLK, I2S_WS, I2S_DATA, SampleReady, ClearFlags;
    logic [31:0] SampleData;
    logic        SampleValid, Overflow, FrameError;
    logic [3:0]  FifoLevel;

    i2s_capture #(.SAMPLE_WIDTH(SW), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
        .CLK(CLK), .Reset(Reset), .Enable(Enable),
        .I2S_CLK(I2S_CLK), .I2S_WS(I2S_WS), .I2S_DATA(I2S_DATA),
        .SampleData(SampleData), .SampleValid(SampleValid), .SampleReady(SampleReady),
        .FifoLevel(FifoLevel), .Overflow(Overflow), .FrameError(FrameError),
        .ClearFlags(ClearFlags)
    );

    always #5 CLK = ~CLK;

    int          checks = 0;
    int          errors = 0;
    int          half   = 4;     // BCLK half period in CLK cycles
    int          lat    = 0;
    logic [31:0] exp_q[$];
    logic        exp_ovf = 1'b0;
    logic        exp_ferr = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Data and WS change while BCLK is low; the DUT samples on the rising edge.
    task automatic send_bit(input logic ws, input logic d, input bit hold_high);
        I2S_CLK  = 1'b0;
        I2S_WS   = ws;
        I2S_DATA = d;
        repeat (half) @(negedge CLK);
        I2S_CLK = 1'b1;
        if (hold_high) repeat (half) @(negedge CLK);
    endtask

    // WS switches on the slot's LSB, one bit ahead of the next slot's MSB.
    task automatic send_slot(input logic [15:0] v, input logic ws_lvl, input bit split_last);
        for (int i = 15; i >= 0; i--)
            send_bit((i == 0) ? ~ws_lvl : ws_lvl, v[i], !(split_last && i == 0));
    endtask

    task automatic send_frame(input logic [31:0] w, input bit split_last);
        send_slot(w[31:16], 1'b0, 1'b0);
        send_slot(w[15:0], 1'b1, split_last);
    endtask

    task automatic send_bits(input int n, input logic ws);
        for (int i = 0; i < n; i++) send_bit(ws, 1'($urandom), 1'b1);
    endtask

    task automatic model_push(input logic [31:0] w);
        if (exp_q.size() < DEPTH) exp_q.push_back(w);
        else                      exp_ovf = 1'b1;
    endtask

    task automatic stream(input int n);
        logic [31:0] w;
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            send_frame(w, 1'b0);
            model_push(w);
        end
    endtask

    task automatic settle();
        repeat (8) @(negedge CLK);
    endtask

    task automatic pop_check(input string tag);
        logic [31:0] e;
        chk({tag, "_valid"}, {31'd0, SampleValid}, 32'd1);
        e = (exp_q.size() > 0) ? exp_q[0] : 32'hDEAD_BEEF;
        chk({tag, "_data"}, SampleData, e);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        SampleReady = 1'b1;
        @(negedge CLK);
        SampleReady = 1'b0;
    endtask

    task automatic drain(input string tag);
        while (exp_q.size() > 0) pop_check(tag);
        chk({tag, "_empty_level"}, {28'd0, FifoLevel}, 32'd0);
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_level"}, {28'd0, FifoLevel}, exp_q.size());
        chk({tag, "_overflow"}, {31'd0, Overflow}, {31'd0, exp_ovf});
        chk({tag, "_frame_error"}, {31'd0, FrameError}, {31'd0, exp_ferr});
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_data"}, SampleData, 32'd0);
        chk({tag, "_valid"}, {31'd0, SampleValid}, 32'd0);
        chk({tag, "_level"}, {28'd0, FifoLevel}, 32'd0);
        chk({tag, "_overflow"}, {31'd0, Overflow}, 32'd0);
        chk({tag, "_frame_error"}, {31'd0, FrameError}, 32'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        int          used;
        Reset = 1'b0; Enable = 1'b0; I2S_CLK = 1'b0; I2S_WS = 1'b0; I2S_DATA = 1'b0;
        SampleReady = 1'b0; ClearFlags = 1'b0;
        repeat (3) @(negedge CLK);
        check_cleared("reset");
        Reset = 1'b1;
        Enable = 1'b1;
        @(negedge CLK);

        // Clean stream near 1.41 MHz BCLK, starting mid-left-slot so the first frame is partial.
        half = 35;
        send_bits(5, 1'b0);
        send_bit(1'b1, 1'b1, 1'b1);
        send_slot(16'($urandom), 1'b1, 1'b0);
        send_frame(32'hA55A_0FF0, 1'b1);
        model_push(32'hA55A_0FF0);
        used = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge CLK);
            used = c;
            if (SampleValid === 1'b1) begin
                lat = c;
                break;
            end
        end
        chk("push_latency_ok", {31'd0, (lat >= 1 && lat <= SYNC + 3)}, 32'd1);
        if (lat == 0) lat = SYNC + 1;
        if (used < half) repeat (half - used) @(negedge CLK);
        send_frame(32'h8001_7FFE, 1'b0);
        model_push(32'h8001_7FFE);
        settle();
        check_state("clean");
        drain("clean");

        // Overflow: ten frames into an eight-deep FIFO with no consumer.
        half = 4;
        stream(10);
        settle();
        check_state("ovf");
        drain("ovf");
        ClearFlags = 1'b1;
        @(negedge CLK);
        ClearFlags = 1'b0;
        exp_ovf = 1'b0;
        check_state("ovf_clear");

        // Full FIFO: pop exactly on the push cycle, so the new frame is accepted without loss.
        stream(DEPTH);
        settle();
        check_state("fill");
        w = $urandom;
        send_frame(w, 1'b1);
        if (lat > 1) repeat (lat - 1) @(negedge CLK);
        chk("full_head", SampleData, exp_q[0]);
        SampleReady = 1'b1;
        @(negedge CLK);
        SampleReady = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back(w);
        if (lat < half) repeat (half - lat) @(negedge CLK);
        settle();
        check_state("full_pushpop");
        drain("full_pushpop");

        // Short slot: WS toggles after 10 left bits; resync on the next WS 1->0.
        send_bits(10, 1'b0);
        send_bits(15, 1'b1);
        send_bit(1'b0, 1'b0, 1'b1);
        exp_ferr = 1'b1;
        settle();
        check_state("short_slot");
        stream(1);
        settle();
        check_state("short_recover");
        drain("short_recover");

        // Enable=0 mid-right-slot: flush, flags held; re-enable mid-left must wait for WS 1->0.
        stream(3);
        settle();
        check_state("pre_disable");
        send_slot(16'($urandom), 1'b0, 1'b0);
        send_bits(8, 1'b1);
        Enable = 1'b0;
        @(negedge CLK);
        exp_q.delete();
        chk("disable_valid", {31'd0, SampleValid}, 32'd0);
        chk("disable_data", SampleData, 32'd0);
        check_state("disable");
        send_bits(7, 1'b1);
        send_bit(1'b0, 1'b0, 1'b1);
        send_bits(8, 1'b0);
        Enable = 1'b1;
        send_bits(7, 1'b0);
        send_bit(1'b1, 1'b1, 1'b1);
        send_slot(16'($urandom), 1'b1, 1'b0);
        stream(1);
        settle();
        check_state("reenable");
        drain("reenable");

        // Async reset mid-right-slot with three words buffered.
        stream(3);
        settle();
        check_state("pre_reset");
        send_slot(16'($urandom), 1'b0, 1'b0);
        send_bits(8, 1'b1);
        #2 Reset = 1'b0;
        #1 check_cleared("mid_reset");
        exp_q.delete();
        exp_ovf = 1'b0;
        exp_ferr = 1'b0;
        @(negedge CLK);
        Reset = 1'b1;
        send_bits(7, 1'b1);
        send_bit(1'b0, 1'b0, 1'b1);
        stream(1);
        settle();
        check_state("post_reset");
        drain("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
